// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command/response codes
// and the host-to-device frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_FIRST,
    SEND,
    ACK,
    WAIT_IDLE,
    ERROR
  } state_t;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;

  // {stop, odd parity, data, start}; bit 0 goes out first.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin with a falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);
  logic meta, cur, prev;

  // Idle PS/2 lines are high; resetting to 1 avoids a phantom fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pin;
      cur  <= meta;
      prev <= cur;
    end
  end

  assign level = cur;
  assign fall  = prev & ~cur;
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device falling edges, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES     = 5000,
  parameter int unsigned SETUP_CYCLES       = 50,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
  parameter int unsigned PACKET_TIMEOUT     = 100000
) (
  input  logic          iCLK_50,
  input  logic          reset,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] FIRST_LAST = 20'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [19:0] PKT_LAST   = 20'(PACKET_TIMEOUT - 1);

  state_t      state, state_n;
  logic [19:0] timer, timer_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic [10:0] shreg, shreg_n;
  logic        dat_oe_q, dat_oe_n;
  logic        clk_lvl, clk_fall, dat_lvl, unused_dat_fall;

  ps2_line_sync u_clk_sync (
    .clk   (iCLK_50),
    .rst   (reset),
    .pin   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (iCLK_50),
    .rst   (reset),
    .pin   (ps2_dat_in),
    .level (dat_lvl),
    .fall  (unused_dat_fall)
  );

  function automatic logic in_packet(input state_t s);
    return (s == SEND) || (s == ACK) || (s == WAIT_IDLE);
  endfunction

  always_ff @(posedge iCLK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bitcnt   <= bitcnt_n;
      shreg    <= shreg_n;
      dat_oe_q <= dat_oe_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer + 20'd1;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    dat_oe_n = dat_oe_q;

    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (bus.tx_valid) begin
          state_n  = INHIBIT;
          shreg_n  = build_frame(bus.tx_data);
          bitcnt_n = '0;
        end
      end
      INHIBIT: begin
        if (timer == INH_LAST) begin
          state_n  = REQ;
          dat_oe_n = 1'b1;
        end
      end
      REQ: begin
        if (timer == SETUP_LAST) state_n = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (clk_fall) begin
          dat_oe_n = ~shreg[1];
          shreg_n  = shreg >> 1;
          bitcnt_n = 4'd1;
          state_n  = SEND;
        end else if (timer == FIRST_LAST) begin
          state_n = ERROR;
        end
      end
      SEND: begin
        if (timer == PKT_LAST) begin
          state_n = ERROR;
        end else if (clk_fall) begin
          dat_oe_n = ~shreg[1];
          shreg_n  = shreg >> 1;
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (timer == PKT_LAST) state_n = ERROR;
        else if (clk_fall)     state_n = dat_lvl ? ERROR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (timer == PKT_LAST)      state_n = ERROR;
        else if (clk_lvl && dat_lvl) state_n = IDLE;
      end
      ERROR: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == IDLE || state_n == ERROR) dat_oe_n = 1'b0;

    // The shared timer doubles as the packet timeout, so it keeps running
    // across SEND -> ACK -> WAIT_IDLE and clears on every other state change.
    if (state_n != state && !(in_packet(state) && in_packet(state_n)))
      timer_n = '0;
  end

  assign ps2_clk_oe   = (state == INHIBIT) || (state == REQ);
  assign ps2_dat_oe   = dat_oe_q;
  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.tx_done  = (state == WAIT_IDLE) && (state_n == IDLE);
  assign bus.tx_error = (state == ERROR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on an
// open-collector clock/data pair; timing parameters are scaled down.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH   = 40;
  localparam int unsigned SET   = 8;
  localparam int unsigned FE    = 600;
  localparam int unsigned PKT   = 1500;
  localparam int unsigned H     = 20;
  localparam int unsigned LIMIT = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe;
  logic clk_pin, dat_pin;

  ps2_host_tx_if bus ();

  assign clk_pin = dev_clk & ~ps2_clk_oe;
  assign dat_pin = dev_dat & ~ps2_dat_oe;

  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES     (INH),
    .SETUP_CYCLES       (SET),
    .FIRST_EDGE_TIMEOUT (FE),
    .PACKET_TIMEOUT     (PKT)
  ) dut (
    .iCLK_50    (clk),
    .reset      (reset),
    .bus        (bus),
    .ps2_clk_in (clk_pin),
    .ps2_dat_in (dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done = 0, n_err = 0, n_inh = 0, n_req = 0, n_bad = 0;

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1)                 n_done <= n_done + 1;
    if (bus.tx_error === 1'b1)                n_err  <= n_err + 1;
    if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) n_inh <= n_inh + 1;
    if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) n_req <= n_req + 1;
    if ((bus.tx_done === 1'b1 && bus.tx_error === 1'b1) ||
        (bus.tx_ready === 1'b1 && ps2_dat_oe === 1'b1))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for clock release, reads the start bit, then gives
  // 'pulses' clock pulses, sampling the data line at the end of each low phase.
  task automatic device(input int unsigned pulses, input logic ack_low,
                        output logic [10:0] bits, output logic ok);
    int unsigned c;
    c    = 0;
    ok   = 1'b1;
    bits = '0;
    while (ps2_clk_oe !== 1'b1 && c < LIMIT) begin @(negedge clk); c++; end
    while (ps2_clk_oe !== 1'b0 && c < LIMIT) begin @(negedge clk); c++; end
    if (c >= LIMIT) begin
      ok = 1'b0;
    end else begin
      repeat (H) @(negedge clk);
      bits[0] = dat_pin;
      for (int unsigned k = 1; k <= pulses; k++) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        if (k <= 10) bits[k] = dat_pin;
        dev_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
        if (k == 10 && ack_low) dev_dat = 1'b0;
        repeat (H / 2) @(negedge clk);
      end
      dev_dat = 1'b1;
    end
    repeat (4 * H) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    logic        ok;
    int          b_done, b_err, b_inh, b_req;
    int unsigned c;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready",  bus.tx_ready, 1);
    check("rst_busy",   bus.busy,     0);
    check("rst_clk_oe", ps2_clk_oe,   0);
    check("rst_dat_oe", ps2_dat_oe,   0);
    check("rst_done",   bus.tx_done,  0);
    check("rst_error",  bus.tx_error, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
    b_done = n_done; b_err = n_err; b_inh = n_inh; b_req = n_req;
    send(CMD_SET_LED);
    check("ed_busy",  bus.busy,     1);
    check("ed_ready", bus.tx_ready, 0);
    device(11, 1'b1, bits, ok);
    check("ed_release", ok, 1);
    check("ed_bits",    bits, 11'h7DA);
    check("ed_inhibit", n_inh - b_inh, INH);
    check("ed_setup",   n_req - b_req, SET);
    check("ed_done",    n_done - b_done, 1);
    check("ed_err",     n_err - b_err, 0);
    check("ed_ready_after", bus.tx_ready, 1);

    // 0xF4: parity 0
    b_done = n_done; b_err = n_err;
    send(CMD_ENABLE);
    device(11, 1'b1, bits, ok);
    check("f4_bits", bits, 11'h5E8);
    check("f4_done", n_done - b_done, 1);

    // 0x00 straight after: parity 1
    b_done = n_done;
    send(8'h00);
    device(11, 1'b1, bits, ok);
    check("z_bits", bits, 11'h600);
    check("z_done", n_done - b_done, 1);
    check("z_err",  n_err - b_err, 0);

    // Device never clocks after release
    b_done = n_done; b_err = n_err;
    send(CMD_ENABLE);
    c = 0;
    while (ps2_clk_oe !== 1'b0 && c < LIMIT) begin @(negedge clk); c++; end
    check("to_start_bit", ps2_dat_oe, 1);
    c = 0;
    while (bus.tx_error !== 1'b1 && c < FE + 100) begin @(negedge clk); c++; end
    check("to_latency", c, FE);
    check("to_clk_oe",  ps2_clk_oe, 0);
    check("to_dat_oe",  ps2_dat_oe, 0);
    check("to_no_done", bus.tx_done, 0);
    @(negedge clk);
    check("to_ready", bus.tx_ready, 1);
    check("to_err_count", n_err - b_err, 1);

    // Device leaves data high at the 11th edge
    b_done = n_done; b_err = n_err;
    send(CMD_ENABLE);
    device(11, 1'b0, bits, ok);
    check("nack_bits", bits, 11'h5E8);
    check("nack_err",  n_err - b_err, 1);
    check("nack_done", n_done - b_done, 0);
    check("nack_ready", bus.tx_ready, 1);

    // Reset after four device falls (bitcnt = 4, d3 of 0x00 being driven low)
    b_err = n_err;
    send(8'h00);
    device(4, 1'b1, bits, ok);
    check("mid_dat_oe", ps2_dat_oe, 1);
    check("mid_busy",   bus.busy,   1);
    check("mid_bits",   bits, 11'h000);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_clk_oe", ps2_clk_oe,   0);
    check("mid_rst_dat_oe", ps2_dat_oe,   0);
    check("mid_rst_ready",  bus.tx_ready, 1);
    check("mid_rst_busy",   bus.busy,     0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_err", n_err - b_err, 0);
    b_done = n_done;
    send(CMD_RESET);
    device(11, 1'b1, bits, ok);
    check("ff_bits", bits, 11'h7FE);
    check("ff_done", n_done - b_done, 1);

    // tx_valid pulses while busy must be dropped
    b_done = n_done; b_inh = n_inh;
    send(CMD_ENABLE);
    fork
      device(11, 1'b1, bits, ok);
      begin
        repeat (20) begin
          repeat (6) @(negedge clk);
          bus.tx_data  = 8'h55;
          bus.tx_valid = 1'b1;
          @(negedge clk);
          bus.tx_valid = 1'b0;
        end
      end
    join
    check("busy_bits", bits, 11'h5E8);
    repeat (3 * INH) @(negedge clk);
    check("busy_one_frame", n_done - b_done, 1);
    check("busy_one_inhibit", n_inh - b_inh, INH);
    check("busy_idle", bus.busy, 0);

    check("no_overlap_or_idle_oe", n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
